// File: rtl/otter_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : otter_pipe_ctrl_if
// Description : Hazard, memory-handshake and stage-control bundle between the
//               OTTER pipeline top level and its sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface otter_pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  // hazard unit and memory handshakes
  logic             stall;
  logic             branch_taken;
  logic             jump;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ack;
  logic             halt_req;

  // pipeline register control
  logic             pc_en;
  logic             pc_sel;
  logic             fe_de_en;
  logic             de_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             v_de;
  logic             v_ex;
  logic             v_mem;
  logic             v_wb;
  logic             halted;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output stall, branch_taken, jump, imem_ready, dmem_req, dmem_ack, halt_req,
    input  pc_en, pc_sel, fe_de_en, de_ex_en, ex_mem_en, mem_wb_en,
    input  v_de, v_ex, v_mem, v_wb, halted,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  stall, branch_taken, jump, imem_ready, dmem_req, dmem_ack, halt_req,
    output pc_en, pc_sel, fe_de_en, de_ex_en, ex_mem_en, mem_wb_en,
    output v_de, v_ex, v_mem, v_wb, halted,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface
`default_nettype wire

// File: rtl/otter_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : otter_pipe_ctrl
// Description : 5-stage OTTER pipeline sequencer: stage enables, bubbles, PC
//               redirect, valid bits and drain-to-halt. Define
//               OTTER_PIPE_PERF_EN to build the stall/flush/wait counters.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_pipe_ctrl #(
  parameter int BOOT_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  otter_pipe_ctrl_if.slave bus
);

  localparam logic [1:0] c_st_boot  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_halt  = 2'd3;

  localparam logic [3:0] c_boot_init = 4'(BOOT_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_boot_cnt;

  logic       r_v_de, r_v_ex, r_v_mem, r_v_wb;
  logic       w_v_de_nxt, w_v_ex_nxt, w_v_mem_nxt, w_v_wb_nxt;
  logic       w_v_nxt_empty;

  logic       w_pc_en, w_pc_sel;
  logic       w_fe_de_en, w_de_ex_en, w_ex_mem_en, w_mem_wb_en;

  logic       w_active;
  logic       w_stopping;
  logic       w_mem_wait;
  logic       w_stall_hit;
  logic       w_redirect_req;

  assign w_active       = (r_state == c_st_run) || (r_state == c_st_drain);
  // The cycle HALT_REQ is first seen in RUN already stops fetching.
  assign w_stopping     = (r_state == c_st_drain) || ((r_state == c_st_run) && bus.halt_req);
  assign w_mem_wait     = w_active && r_v_mem && bus.dmem_req && !bus.dmem_ack;
  assign w_stall_hit    = w_active && !w_mem_wait && bus.stall && r_v_de;
  assign w_redirect_req = (bus.branch_taken || bus.jump) && r_v_de;
  assign w_v_nxt_empty  = !(w_v_de_nxt || w_v_ex_nxt || w_v_mem_nxt || w_v_wb_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_boot;
      r_boot_cnt <= c_boot_init;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == c_st_boot) && (r_boot_cnt != 4'd0)) begin
        r_boot_cnt <= r_boot_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_boot: begin
        if (r_boot_cnt == 4'd0) w_state_nxt = c_st_run;
      end
      c_st_run: begin
        if (bus.halt_req && !w_mem_wait) begin
          w_state_nxt = w_v_nxt_empty ? c_st_halt : c_st_drain;
        end
      end
      c_st_drain: begin
        if (!bus.halt_req)     w_state_nxt = c_st_run;
        else if (w_v_nxt_empty) w_state_nxt = c_st_halt;
      end
      c_st_halt: begin
        if (!bus.halt_req) w_state_nxt = c_st_run;
      end
      default: w_state_nxt = c_st_boot;
    endcase
  end

  always_comb begin
    w_pc_en     = 1'b0;
    w_pc_sel    = 1'b0;
    w_fe_de_en  = 1'b0;
    w_de_ex_en  = 1'b0;
    w_ex_mem_en = 1'b0;
    w_mem_wb_en = 1'b0;
    w_v_de_nxt  = r_v_de;
    w_v_ex_nxt  = r_v_ex;
    w_v_mem_nxt = r_v_mem;
    w_v_wb_nxt  = r_v_wb;
    if (w_active && !w_mem_wait) begin
      w_de_ex_en  = 1'b1;
      w_ex_mem_en = 1'b1;
      w_mem_wb_en = 1'b1;
      w_v_mem_nxt = r_v_ex;
      w_v_wb_nxt  = r_v_mem;
      if (w_stall_hit) begin
        // FE/DE holds the stalled instruction; a bubble enters EX.
        w_v_ex_nxt = 1'b0;
      end else begin
        w_fe_de_en = 1'b1;
        w_v_ex_nxt = r_v_de;
        w_v_de_nxt = 1'b0;
        if (!w_stopping) begin
          if (w_redirect_req) begin
            w_pc_en  = 1'b1;
            w_pc_sel = 1'b1;
          end else if (bus.imem_ready) begin
            w_pc_en    = 1'b1;
            w_v_de_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_de  <= 1'b0;
      r_v_ex  <= 1'b0;
      r_v_mem <= 1'b0;
      r_v_wb  <= 1'b0;
    end else begin
      r_v_de  <= w_v_de_nxt;
      r_v_ex  <= w_v_ex_nxt;
      r_v_mem <= w_v_mem_nxt;
      r_v_wb  <= w_v_wb_nxt;
    end
  end

  assign bus.pc_en     = rst_n && w_pc_en;
  assign bus.pc_sel    = rst_n && w_pc_sel;
  assign bus.fe_de_en  = rst_n && w_fe_de_en;
  assign bus.de_ex_en  = rst_n && w_de_ex_en;
  assign bus.ex_mem_en = rst_n && w_ex_mem_en;
  assign bus.mem_wb_en = rst_n && w_mem_wb_en;
  assign bus.v_de      = r_v_de;
  assign bus.v_ex      = r_v_ex;
  assign bus.v_mem     = r_v_mem;
  assign bus.v_wb      = r_v_wb;
  assign bus.halted    = (r_state == c_st_halt);

`ifdef OTTER_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;

  // Squashes in DRAIN count as flushes even though the PC is not loaded.
  assign w_flush_evt = w_active && !w_mem_wait && !w_stall_hit && w_redirect_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
      r_wait_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_stall_hit && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + c_cnt_one;
      if (w_mem_wait  && (r_wait_cnt  != {CNT_W{1'b1}})) r_wait_cnt  <= r_wait_cnt  + c_cnt_one;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
  assign bus.wait_cnt  = r_wait_cnt;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
  assign bus.wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_otter_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_pipe_ctrl
// Description : Directed and randomized self-checking bench for otter_pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_pipe_ctrl;
  localparam int BOOT_CYCLES = 1;
  localparam int CNT_W       = 32;
`ifdef OTTER_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  otter_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  otter_pipe_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 boot, 1 run, 2 drain, 3 halt; pipe = {de,ex,mem,wb}
  int          m_mode;
  int          m_boot_left;
  bit    [3:0] m_pipe;
  longint      m_stall, m_flush, m_wait;

  function automatic void model_eval(output bit [5:0] en, output bit [3:0] pipe_n,
                                     output int mode_n, output bit ev_s, output bit ev_f,
                                     output bit ev_w);
    bit active, stopping, redirect, fetched;
    bit [1:0] pc;
    en = 6'b0; pipe_n = m_pipe; ev_s = 0; ev_f = 0; ev_w = 0;
    active   = (m_mode == 1) || (m_mode == 2);
    stopping = (m_mode == 2) || (m_mode == 1 && bus.halt_req);
    if (active) begin
      if (m_pipe[1] && bus.dmem_req && !bus.dmem_ack) begin
        ev_w = 1;
      end else if (bus.stall && m_pipe[3]) begin
        en = 6'b000111;
        pipe_n = {m_pipe[3], 1'b0, m_pipe[2], m_pipe[1]};
        ev_s = 1;
      end else begin
        redirect = (bus.branch_taken || bus.jump) && m_pipe[3];
        ev_f = redirect;
        if (stopping)             begin pc = 2'b00; fetched = 0; end
        else if (redirect)        begin pc = 2'b11; fetched = 0; end
        else if (bus.imem_ready)  begin pc = 2'b10; fetched = 1; end
        else                      begin pc = 2'b00; fetched = 0; end
        en = {pc, 4'b1111};
        pipe_n = {fetched, m_pipe[3:1]};
      end
    end
    mode_n = m_mode;
    case (m_mode)
      0: mode_n = (m_boot_left <= 1) ? 1 : 0;
      1: if (bus.halt_req && !ev_w) mode_n = (pipe_n == 0) ? 3 : 2;
      2: if (!bus.halt_req) mode_n = 1; else if (pipe_n == 0) mode_n = 3;
      default: mode_n = bus.halt_req ? 3 : 1;
    endcase
  endfunction

  function automatic longint sat_inc(longint v);
    longint lim = (longint'(1) << CNT_W) - 1;
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_boot_left = BOOT_CYCLES; m_pipe = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.jump = 0; bus.imem_ready = 1;
    bus.dmem_req = 0; bus.dmem_ack = 0; bus.halt_req = 0;
  endtask

  // Advance one clock with model and DUT in lockstep; ends at a falling edge.
  task automatic tick();
    bit [5:0] en; bit [3:0] pn; int mn; bit es, ef, ew;
    model_eval(en, pn, mn, es, ef, ew);
    @(posedge clk);
    if (m_mode == 0 && m_boot_left > 1) m_boot_left--;
    m_pipe = pn; m_mode = mn;
    if (PERF && es) m_stall = sat_inc(m_stall);
    if (PERF && ef) m_flush = sat_inc(m_flush);
    if (PERF && ew) m_wait  = sat_inc(m_wait);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic fill_pipe();
    do_reset();
    repeat (BOOT_CYCLES + 4) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      {bus.stall, bus.branch_taken, bus.jump, bus.imem_ready} = 4'($urandom);
      {bus.dmem_req, bus.dmem_ack, bus.halt_req} = 3'($urandom);
      #1;
      checks++;
      if ({bus.pc_en, bus.pc_sel, bus.fe_de_en, bus.de_ex_en, bus.ex_mem_en, bus.mem_wb_en} !== 6'b0) begin
        errors++;
        $display("FAIL reset_enables: got %b expected 000000",
                 {bus.pc_en, bus.pc_sel, bus.fe_de_en, bus.de_ex_en, bus.ex_mem_en, bus.mem_wb_en});
      end
      checks++;
      if ({bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb, bus.halted} !== 5'b0) begin
        errors++;
        $display("FAIL reset_valid_halted: got %b expected 00000",
                 {bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb, bus.halted});
      end
      @(negedge clk);
    end
    checks++;
    if ((bus.stall_cnt | bus.flush_cnt | bus.wait_cnt) !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
               bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
    end
  endtask

  task automatic test_boot_fill();
    do_reset();
    checks++;
    if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL boot_pc_en: got %b expected 0", bus.pc_en); end
    tick(); #1;
    checks++;
    if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL run_pc_en: got %b expected 1", bus.pc_en); end
    for (int i = 1; i <= 4; i++) begin
      bit [3:0] exp_v;
      tick(); #1;
      exp_v = 4'b1111 << (4 - i);
      checks++;
      if ({bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb} !== exp_v) begin
        errors++;
        $display("FAIL fill_valid_%0d: got %b expected %b", i, {bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb}, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    fill_pipe();
    bus.stall = 1; #1;
    checks++;
    if ({bus.pc_en, bus.fe_de_en, bus.de_ex_en} !== 3'b001) begin
      errors++; $display("FAIL stall_enables: got %b expected 001", {bus.pc_en, bus.fe_de_en, bus.de_ex_en});
    end
    tick(); bus.stall = 0; #1;
    checks++;
    if ({bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb} !== 4'b1011) begin
      errors++; $display("FAIL stall_bubble_ex: got %b expected 1011", {bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb});
    end
    tick(); #1;
    checks++;
    if ({bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb} !== 4'b1101) begin
      errors++; $display("FAIL stall_bubble_mem: got %b expected 1101", {bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb});
    end
  endtask

  task automatic test_jump();
    fill_pipe();
    bus.jump = 1; #1;
    checks++;
    if ({bus.pc_en, bus.pc_sel} !== 2'b11) begin
      errors++; $display("FAIL jump_pc: got %b expected 11", {bus.pc_en, bus.pc_sel});
    end
    tick(); bus.jump = 0; #1;
    checks++;
    if ({bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb} !== 4'b0111) begin
      errors++; $display("FAIL jump_squash: got %b expected 0111", {bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb});
    end
    checks++;
    if (bus.flush_cnt !== CNT_W'(PERF ? 1 : 0)) begin
      errors++; $display("FAIL jump_flush_cnt: got %0d expected %0d", bus.flush_cnt, PERF ? 1 : 0);
    end
  endtask

  task automatic test_mem_wait();
    fill_pipe();
    bus.dmem_req = 1; bus.dmem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.pc_en, bus.pc_sel, bus.fe_de_en, bus.de_ex_en, bus.ex_mem_en, bus.mem_wb_en,
           bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb} !== 10'b000000_1111) begin
        errors++;
        $display("FAIL mem_wait_%0d: got %b expected 0000001111", i,
                 {bus.pc_en, bus.pc_sel, bus.fe_de_en, bus.de_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                  bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb});
      end
      tick();
    end
    bus.dmem_ack = 1; #1;
    checks++;
    if ({bus.pc_en, bus.fe_de_en, bus.mem_wb_en} !== 3'b111) begin
      errors++; $display("FAIL mem_ack_release: got %b expected 111", {bus.pc_en, bus.fe_de_en, bus.mem_wb_en});
    end
    checks++;
    if (bus.wait_cnt !== CNT_W'(PERF ? 3 : 0)) begin
      errors++; $display("FAIL wait_cnt: got %0d expected %0d", bus.wait_cnt, PERF ? 3 : 0);
    end
    tick();
  endtask

  task automatic test_stall_branch();
    fill_pipe();
    bus.stall = 1; bus.branch_taken = 1; #1;
    checks++;
    if ({bus.pc_en, bus.pc_sel} !== 2'b00) begin
      errors++; $display("FAIL stall_branch_sel: got %b expected 00", {bus.pc_en, bus.pc_sel});
    end
    tick(); bus.stall = 0; #1;
    checks++;
    if ({bus.pc_en, bus.pc_sel} !== 2'b11) begin
      errors++; $display("FAIL branch_after_stall: got %b expected 11", {bus.pc_en, bus.pc_sel});
    end
    tick(); bus.branch_taken = 0;
  endtask

  task automatic test_halt();
    fill_pipe();
    bus.halt_req = 1;
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      checks++;
      if (bus.halted !== (i == 4)) begin
        errors++; $display("FAIL halt_cycle_%0d: got %b expected %b", i, bus.halted, i == 4);
      end
    end
    bus.halt_req = 0; #1;
    checks++;
    if ({bus.halted, bus.pc_en} !== 2'b10) begin
      errors++; $display("FAIL halt_release_same: got %b expected 10", {bus.halted, bus.pc_en});
    end
    tick(); #1;
    checks++;
    if ({bus.halted, bus.pc_en} !== 2'b01) begin
      errors++; $display("FAIL halt_release_next: got %b expected 01", {bus.halted, bus.pc_en});
    end
  endtask

  task automatic test_async_reset();
    fill_pipe();
    #2 rst_n = 0; #1;
    checks++;
    if ({bus.pc_en, bus.fe_de_en, bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000000",
               {bus.pc_en, bus.fe_de_en, bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb});
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    bit [5:0] en; bit [3:0] pn; int mn; bit es, ef, ew;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.stall        = ($urandom_range(99) < 15);
      bus.branch_taken = ($urandom_range(99) < 10);
      bus.jump         = ($urandom_range(99) < 5);
      bus.imem_ready   = ($urandom_range(99) < 85);
      bus.dmem_req     = ($urandom_range(99) < 40);
      bus.dmem_ack     = ($urandom_range(99) < 60);
      if ($urandom_range(99) < 3) bus.halt_req = !bus.halt_req;
      #1;
      model_eval(en, pn, mn, es, ef, ew);
      checks++;
      if ({bus.pc_en, bus.pc_sel, bus.fe_de_en, bus.de_ex_en, bus.ex_mem_en, bus.mem_wb_en} !== en) begin
        errors++;
        $display("FAIL rand_enables @%0d: got %b expected %b", cyc,
                 {bus.pc_en, bus.pc_sel, bus.fe_de_en, bus.de_ex_en, bus.ex_mem_en, bus.mem_wb_en}, en);
      end
      checks++;
      if ({bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb, bus.halted} !== {m_pipe, m_mode == 3}) begin
        errors++;
        $display("FAIL rand_valid @%0d: got %b expected %b", cyc,
                 {bus.v_de, bus.v_ex, bus.v_mem, bus.v_wb, bus.halted}, {m_pipe, m_mode == 3});
      end
      checks++;
      if (bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush) ||
          bus.wait_cnt !== CNT_W'(m_wait)) begin
        errors++;
        $display("FAIL rand_counters @%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", cyc,
                 bus.stall_cnt, bus.flush_cnt, bus.wait_cnt, m_stall, m_flush, m_wait);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_boot_fill();
    test_stall();
    test_jump();
    test_mem_wait();
    test_stall_branch();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
